spi_frame_sequencer: RTL

//  Feeds the spi_master one fixed-length frame of words per start, and collects the words shifted back.
//  - Upstream: TX frame buffer, written by the application.
//  - Downstream: RX frame buffer, read by the application.
//  - Sits between the application (e.g. blinker/keys, later HPS bridge) and the spi_master di_/do_ handshake.

---
 rtl/spi_frame_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_sequencer.sv
// Frame sequencer between the application TX/RX word buffers and the spi_master
// di_/do_ handshake: one start sends FRAME_LEN words and stores the words returned.
//
// state  | meaning
// IDLE   | waiting for start, TX buffer writable
// REQ    | waiting for spi_master to request the next tx word
// WRITE  | wren_o held with di_o until wr_ack_i
// DRAIN  | all tx words handed over, waiting for remaining rx words
// FINISH | one-cycle done pulse, back to IDLE
module spi_frame_sequencer #(
  parameter int WORD_W    = 16,
  parameter int FRAME_LEN = 12,
  parameter int ADDR_W    = 4,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic              tx_we,
  input  logic [ADDR_W-1:0] tx_addr,
  input  logic [WORD_W-1:0] tx_data,
  input  logic [ADDR_W-1:0] rx_addr,
  output logic [WORD_W-1:0] rx_data,
  input  logic              di_req_i,
  output logic [WORD_W-1:0] di_o,
  output logic              wren_o,
  input  logic              wr_ack_i,
  input  logic              do_valid_i,
  input  logic [WORD_W-1:0] do_i
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [ADDR_W:0] LEN     = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [TW-1:0]   T_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]   T_ONE   = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WRITE,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t state_q, state_d;

  logic [WORD_W-1:0] txbuf [FRAME_LEN];
  logic [WORD_W-1:0] rxbuf [FRAME_LEN];

  logic [ADDR_W:0]   tx_ptr_q, tx_ptr_d;
  logic [ADDR_W:0]   rx_ptr_q, rx_ptr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              wren_q, wren_d;
  logic [WORD_W-1:0] di_q, di_d;
  logic              error_q, error_d;
  logic              shadow_v_q;
  logic [ADDR_W-1:0] shadow_addr_q;
  logic [WORD_W-1:0] shadow_data_q;
  logic [WORD_W-1:0] tx_word;
  logic              tx_in_range, rx_in_range, rx_fire, progress, accept_start;

  assign busy   = (state_q == S_REQ) || (state_q == S_WRITE) || (state_q == S_DRAIN);
  assign done   = (state_q == S_FINISH);
  assign error  = error_q;
  assign wren_o = wren_q;
  assign di_o   = di_q;

  assign tx_in_range  = ({1'b0, tx_addr} < LEN);
  assign rx_in_range  = ({1'b0, rx_addr} < LEN);
  assign rx_fire      = busy && do_valid_i && (rx_ptr_q < LEN);
  assign progress     = wr_ack_i || do_valid_i;
  assign accept_start = (state_q == S_IDLE) && start;

  // A write landing in the start cycle must not leak into the frame: the
  // overwritten word is kept aside and substituted when its slot is sent.
  always_comb begin
    tx_word = txbuf[tx_ptr_q[ADDR_W-1:0]];
    if (shadow_v_q && (shadow_addr_q == tx_ptr_q[ADDR_W-1:0]))
      tx_word = shadow_data_q;
  end

  always_comb begin
    state_d  = state_q;
    tx_ptr_d = tx_ptr_q;
    rx_ptr_d = rx_ptr_q;
    timer_d  = timer_q;
    wren_d   = wren_q;
    di_d     = di_q;
    error_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_ptr_d = '0;
          rx_ptr_d = '0;
          timer_d  = T_LOAD;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (di_req_i) begin
          di_d    = tx_word;
          wren_d  = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_ack_i) begin
          wren_d   = 1'b0;
          tx_ptr_d = tx_ptr_q + PTR_ONE;
          state_d  = (tx_ptr_q == LAST) ? S_DRAIN : S_REQ;
        end
      end
      S_DRAIN:  state_d = S_DRAIN;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Timer counts down from TIMEOUT-1; expiry at zero with no progress.
    if (busy) begin
      if (rx_fire)
        rx_ptr_d = rx_ptr_q + PTR_ONE;
      if (progress)
        timer_d = T_LOAD;
      else if (timer_q != '0)
        timer_d = timer_q - T_ONE;

      if (rx_fire && (rx_ptr_q == LAST)) begin
        state_d = S_FINISH;
        wren_d  = 1'b0;
      end else if (!progress && (timer_q == '0)) begin
        state_d = S_IDLE;
        wren_d  = 1'b0;
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      tx_ptr_q      <= '0;
      rx_ptr_q      <= '0;
      timer_q       <= T_LOAD;
      wren_q        <= 1'b0;
      di_q          <= '0;
      error_q       <= 1'b0;
      shadow_v_q    <= 1'b0;
      shadow_addr_q <= '0;
      shadow_data_q <= '0;
      rx_data       <= '0;
    end else begin
      state_q  <= state_d;
      tx_ptr_q <= tx_ptr_d;
      rx_ptr_q <= rx_ptr_d;
      timer_q  <= timer_d;
      wren_q   <= wren_d;
      di_q     <= di_d;
      error_q  <= error_d;
      if (accept_start) begin
        shadow_v_q    <= tx_we && tx_in_range;
        shadow_addr_q <= tx_addr;
        shadow_data_q <= tx_in_range ? txbuf[tx_addr] : '0;
      end
      rx_data <= rx_in_range ? rxbuf[rx_addr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_we && !busy && tx_in_range)
      txbuf[tx_addr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rx_fire)
      rxbuf[rx_ptr_q[ADDR_W-1:0]] <= do_i;
  end

endmodule
